// File: rtl/rv32_imm_gen_pkg.sv
// Opcodes and immediate-format codes shared by the RV32I decode path.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/rv32_imm_gen_decode.sv
// Combinational opcode decode and I/S/B/U/J immediate extraction, sign-extended to XLEN.
// Zero latency; no flow control.
module rv32_imm_decode
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        imm_fmt,
    output logic            unknown_op
);

    logic [31:0] imm32;

    // Unknown or X opcodes fall to the default arm, leaving NONE/0.
    always_comb begin
        imm32      = '0;
        imm_fmt    = FMT_NONE;
        unknown_op = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                imm_fmt = FMT_I;
            end
            OPC_STORE: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {instr[31:12], 12'b0};
                imm_fmt = FMT_U;
            end
            OPC_JAL: begin
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_fmt = FMT_J;
            end
            OPC_OP: begin
                imm32   = '0;
                imm_fmt = FMT_NONE;
            end
            default: begin
                unknown_op = 1'b1;
            end
        endcase
    end

    // Bit 31 is the sign for every format, U-type included, so a signed widen covers XLEN=64.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator: decode plus optional output register.
// Latency 1 cycle (REG_OUT=1) or 0 (REG_OUT=0); accepts one instr per cycle, no backpressure.
module rv32_imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    output logic            out_valid,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic            unknown_op
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_unknown;

    rv32_imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr      (instr),
        .imm        (dec_imm),
        .imm_fmt    (dec_fmt),
        .unknown_op (dec_unknown)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic            out_valid_q, out_valid_d;
            logic [XLEN-1:0] imm_q, imm_d;
            imm_fmt_e        imm_fmt_q, imm_fmt_d;
            logic            unknown_op_q, unknown_op_d;

            // Payload holds when in_valid is low; only out_valid tracks every cycle.
            always_comb begin
                out_valid_d  = in_valid;
                imm_d        = imm_q;
                imm_fmt_d    = imm_fmt_q;
                unknown_op_d = unknown_op_q;
                if (in_valid) begin
                    imm_d        = dec_imm;
                    imm_fmt_d    = dec_fmt;
                    unknown_op_d = dec_unknown;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q  <= 1'b0;
                    imm_q        <= '0;
                    imm_fmt_q    <= FMT_NONE;
                    unknown_op_q <= 1'b0;
                end else begin
                    out_valid_q  <= out_valid_d;
                    imm_q        <= imm_d;
                    imm_fmt_q    <= imm_fmt_d;
                    unknown_op_q <= unknown_op_d;
                end
            end

            assign out_valid  = out_valid_q;
            assign imm        = imm_q;
            assign imm_fmt    = imm_fmt_q;
            assign unknown_op = unknown_op_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign out_valid  = in_valid;
            assign imm        = dec_imm;
            assign imm_fmt    = dec_fmt;
            assign unknown_op = dec_unknown;
        end
    endgenerate

endmodule

// File: tb/tb_rv32_imm_gen.sv
// Scoreboarded bench for rv32_imm_gen, registered and combinational builds side by side.
module tb_rv32_imm_gen;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        unk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;

    logic        r_vld, c_vld;
    logic [31:0] r_imm, c_imm;
    logic [2:0]  r_fmt, c_fmt;
    logic        r_unk, c_unk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam int NTV = 15;
    logic [31:0] tv_ins [NTV] = '{
        32'h4D200013, 32'hE5900013, 32'hC1800013, 32'h31300013,
        32'h4C000923, 32'hE4000CA3, 32'hC0000C23, 32'h300009A3,
        32'hC8000763, 32'h78000563, 32'hABCDE0B7, 32'h800000EF,
        32'h7FFFF0EF, 32'h0000007F, 32'h00B50533
    };
    exp_t tv_exp [NTV] = '{
        '{32'h000004D2, 3'd1, 1'b0}, '{32'hFFFFFE59, 3'd1, 1'b0},
        '{32'hFFFFFC18, 3'd1, 1'b0}, '{32'h00000313, 3'd1, 1'b0},
        '{32'h000004D2, 3'd2, 1'b0}, '{32'hFFFFFE59, 3'd2, 1'b0},
        '{32'hFFFFFC18, 3'd2, 1'b0}, '{32'h00000313, 3'd2, 1'b0},
        '{32'hFFFFF48E, 3'd3, 1'b0}, '{32'h0000078A, 3'd3, 1'b0},
        '{32'hABCDE000, 3'd4, 1'b0}, '{32'hFFF00000, 3'd5, 1'b0},
        '{32'h000FFFFE, 3'd5, 1'b0}, '{32'h00000000, 3'd0, 1'b1},
        '{32'h00000000, 3'd0, 1'b0}
    };

    rv32_imm_gen #(.XLEN(32), .REG_OUT(1'b1)) dut_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .instr      (instr),
        .out_valid  (r_vld),
        .imm        (r_imm),
        .imm_fmt    (r_fmt),
        .unknown_op (r_unk)
    );

    rv32_imm_gen #(.XLEN(32), .REG_OUT(1'b0)) dut_comb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .instr      (instr),
        .out_valid  (c_vld),
        .imm        (c_imm),
        .imm_fmt    (c_fmt),
        .unknown_op (c_unk)
    );

    always #5 clk = ~clk;

    // Reference built arithmetically from the signed word rather than by bit concatenation.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int   s;
        s = $signed(ins);
        e = '{32'h0, 3'd0, 1'b0};
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                e.imm = 32'(s >>> 20);
                e.fmt = 3'd1;
            end
            7'h23: begin
                e.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
                e.fmt = 3'd2;
            end
            7'h63: begin
                e.imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11)
                      | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin
                e.imm = ins & 32'hFFFFF000;
                e.fmt = 3'd4;
            end
            7'h6F: begin
                e.imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12)
                      | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                e.fmt = 3'd5;
            end
            7'h33: e.unk = 1'b0;
            default: e.unk = 1'b1;
        endcase
        return e;
    endfunction

    task automatic send(input logic [31:0] ins, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h4D200013;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h0, 3'd0, 1'b0})
            $display("FAIL reset_hold: got vld=%b imm=%h fmt=%0d unk=%b, want all zero",
                     r_vld, r_imm, r_fmt, r_unk);
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h0, 3'd0, 1'b0}) errors++;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got vld=%b imm=%h fmt=%0d unk=%b, want all zero",
                     r_vld, r_imm, r_fmt, r_unk);
        end
    endtask

    task automatic test_decode_table;
        exp_t e;
        for (int i = 0; i < NTV; i++) begin
            send(tv_ins[i], tv_exp[i]);
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL decode_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b1, e.imm, e.fmt, e.unk}) begin
                    errors++;
                    $display("FAIL decode_%0d instr=%h: got vld=%b imm=%h fmt=%0d unk=%b, want vld=1 imm=%h fmt=%0d unk=%b",
                             i, tv_ins[i], r_vld, r_imm, r_fmt, r_unk, e.imm, e.fmt, e.unk);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [6:0]  opcs [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                   7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
        logic [31:0] ins;
        exp_t        e;
        exp_t        prev;
        prev = '{32'h0, 3'd0, 1'b0};
        for (int i = 0; i < 32; i++) begin
            ins = $urandom;
            if (i % 8 != 7)
                ins[6:0] = opcs[$urandom_range(0, 10)];
            send(ins, model(ins));
            #1;
            if (i > 0) begin
                checks++;
                if (r_imm !== prev.imm) begin
                    errors++;
                    $display("FAIL b2b_lag_%0d: got imm=%h before edge, want previous %h", i, r_imm, prev.imm);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                prev = e;
                if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b1, e.imm, e.fmt, e.unk}) begin
                    errors++;
                    $display("FAIL b2b_%0d instr=%h: got vld=%b imm=%h fmt=%0d unk=%b, want vld=1 imm=%h fmt=%0d unk=%b",
                             i, ins, r_vld, r_imm, r_fmt, r_unk, e.imm, e.fmt, e.unk);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_hold;
        exp_t e;
        send(32'h31300013, '{32'h00000313, 3'd1, 1'b0});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b1, e.imm, e.fmt, e.unk}) begin
            errors++;
            $display("FAIL hold_load: got vld=%b imm=%h fmt=%0d unk=%b, want vld=1 imm=%h fmt=%0d",
                     r_vld, r_imm, r_fmt, r_unk, e.imm, e.fmt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        instr    = 32'h0000007F;
        @(posedge clk);
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h00000313, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL hold_reg_1: got vld=%b imm=%h fmt=%0d unk=%b, want vld=0 imm=00000313 fmt=1 unk=0",
                     r_vld, r_imm, r_fmt, r_unk);
        end
        checks++;
        if ({c_vld, c_imm, c_fmt, c_unk} !== {1'b0, 32'h0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL hold_comb_1: got vld=%b imm=%h fmt=%0d unk=%b, want vld=0 imm=0 fmt=0 unk=1",
                     c_vld, c_imm, c_fmt, c_unk);
        end
        @(negedge clk);
        instr = 32'hABCDE0B7;
        @(posedge clk);
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h00000313, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL hold_reg_2: got vld=%b imm=%h fmt=%0d unk=%b, want vld=0 imm=00000313 fmt=1 unk=0",
                     r_vld, r_imm, r_fmt, r_unk);
        end
        checks++;
        if ({c_vld, c_imm, c_fmt, c_unk} !== {1'b0, 32'hABCDE000, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL hold_comb_2: got vld=%b imm=%h fmt=%0d unk=%b, want vld=0 imm=abcde000 fmt=4 unk=0",
                     c_vld, c_imm, c_fmt, c_unk);
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        send(32'hABCDE0B7, '{32'hABCDE000, 3'd4, 1'b0});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b1, e.imm, e.fmt, e.unk}) begin
            errors++;
            $display("FAIL arst_pre: got vld=%b imm=%h fmt=%0d, want vld=1 imm=%h fmt=%0d",
                     r_vld, r_imm, r_fmt, e.imm, e.fmt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL arst_clear: got vld=%b imm=%h fmt=%0d unk=%b, want all zero without a clock edge",
                     r_vld, r_imm, r_fmt, r_unk);
        end
        checks++;
        if ({c_vld, c_imm, c_fmt, c_unk} !== {1'b1, 32'hABCDE000, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL arst_comb: got vld=%b imm=%h fmt=%0d unk=%b, want vld=1 imm=abcde000 fmt=4 unk=0",
                     c_vld, c_imm, c_fmt, c_unk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({r_vld, r_imm, r_fmt, r_unk} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL arst_after: got vld=%b imm=%h fmt=%0d unk=%b, want all zero",
                     r_vld, r_imm, r_fmt, r_unk);
        end
    endtask

    task automatic test_comb;
        for (int i = 0; i < NTV; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = tv_ins[i];
            #1;
            checks++;
            if ({c_vld, c_imm, c_fmt, c_unk} !== {1'b1, tv_exp[i].imm, tv_exp[i].fmt, tv_exp[i].unk}) begin
                errors++;
                $display("FAIL comb_%0d instr=%h: got vld=%b imm=%h fmt=%0d unk=%b, want vld=1 imm=%h fmt=%0d unk=%b",
                         i, tv_ins[i], c_vld, c_imm, c_fmt, c_unk,
                         tv_exp[i].imm, tv_exp[i].fmt, tv_exp[i].unk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (c_vld !== 1'b0) begin
            errors++;
            $display("FAIL comb_valid_low: got vld=%b, want 0", c_vld);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = 32'h0;
        test_reset();
        test_decode_table();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_comb();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
